// File: rtl/sm83_pkg.sv
// ---------------------------------------------------------------------------
// sm83_pkg
// Shared types for the SM83 core's arithmetic path: the 8-bit ALU opcode,
// the flag register layout, the 16-bit sequencer opcode and state, and the
// flag-merge rule the 16-bit sequencer applies when it finishes an operation.
// ---------------------------------------------------------------------------
package sm83_pkg;

  typedef logic [7:0] data_t;

  // F register bits in architectural order (Z N H C).
  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } flags_t;

  typedef enum logic [2:0] {
    ALU_NOP,
    ALU_ADD,
    ALU_ADC,
    ALU_SUB,
    ALU_SBC
  } alu_op_t;

  typedef enum logic [1:0] {
    ALU16_ADD_HL,
    ALU16_ADD_SP,
    ALU16_INC,
    ALU16_DEC
  } alu16_op_t;

  typedef enum logic [1:0] {
    ALU16_ST_IDLE,
    ALU16_ST_LO,
    ALU16_ST_HI,
    ALU16_ST_DONE
  } alu16_state_t;

  // ADD HL keeps Z and reports H/C from bit 11/15; ADD SP clears Z/N and
  // reports H/C from the low byte (bit 3/7); INC rr / DEC rr leave F alone.
  function automatic flags_t alu16_merge_flags(alu16_op_t op, flags_t in_flags,
                                               logic h_lo, logic c_lo,
                                               logic h_hi, logic c_hi);
    flags_t f;
    f = in_flags;
    case (op)
      ALU16_ADD_HL: begin
        f.n = 1'b0;
        f.h = h_hi;
        f.c = c_hi;
      end
      ALU16_ADD_SP: begin
        f.z = 1'b0;
        f.n = 1'b0;
        f.h = h_lo;
        f.c = c_lo;
      end
      default: f = in_flags;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu16_seq.sv
// ---------------------------------------------------------------------------
// alu16_seq
// Runs SM83 16-bit arithmetic (ADD HL,rr / ADD SP,e8 / INC rr / DEC rr) as
// two passes over the shared 8-bit ALU: low byte first, then high byte with
// the low-byte carry chained in. The ALU is requested with alu_req and only
// advances a pass on a cycle where alu_gnt is high.
//
// Ports
//   clk, rst        core clock, synchronous active-high reset
//   start, op       launch request (sampled only in IDLE) and operation
//   opa, opb        16-bit operands (opb[7:0] is e8 for ADD SP)
//   in_flags        F at launch time
//   busy, done      op in flight / one-cycle completion pulse
//   result          16-bit result, held until the next done
//   out_flags       merged F, held with result
//   alu_req/alu_gnt request/grant handshake with the ALU operand mux
//   alu_op, alu_op1, alu_op2, alu_in_flags   operands driven to the ALU
//   alu_result, alu_out_flags                combinational ALU outputs
//
// Build option
//   ALU16_FAST_INCDEC_EN : INC/DEC use a local 16-bit incrementer, never
//   request the ALU and complete one cycle after start.
// ---------------------------------------------------------------------------
module alu16_seq
  import sm83_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  alu16_op_t    op,
  input  logic [15:0]  opa,
  input  logic [15:0]  opb,
  input  flags_t       in_flags,
  output logic         busy,
  output logic         done,
  output logic [15:0]  result,
  output flags_t       out_flags,
  output logic         alu_req,
  input  logic         alu_gnt,
  output alu_op_t      alu_op,
  output data_t        alu_op1,
  output data_t        alu_op2,
  output flags_t       alu_in_flags,
  input  data_t        alu_result,
  input  flags_t       alu_out_flags
);

  alu16_state_t state_q, state_d;
  alu16_op_t    op_q, op_d;
  logic [15:0]  opa_q, opa_d;
  logic [15:0]  opb_q, opb_d;
  flags_t       flags_q, flags_d;
  data_t        res_lo_q, res_lo_d;
  logic         carry_q, carry_d;
  logic         h_lo_q, h_lo_d;
  logic [15:0]  result_q, result_d;
  flags_t       out_flags_q, out_flags_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ALU16_ST_IDLE;
      op_q        <= ALU16_ADD_HL;
      opa_q       <= '0;
      opb_q       <= '0;
      flags_q     <= '0;
      res_lo_q    <= '0;
      carry_q     <= 1'b0;
      h_lo_q      <= 1'b0;
      result_q    <= '0;
      out_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      flags_q     <= flags_d;
      res_lo_q    <= res_lo_d;
      carry_q     <= carry_d;
      h_lo_q      <= h_lo_d;
      result_q    <= result_d;
      out_flags_q <= out_flags_d;
    end
  end

  // Next-state and datapath capture
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    flags_d     = flags_q;
    res_lo_d    = res_lo_q;
    carry_d     = carry_q;
    h_lo_d      = h_lo_q;
    result_d    = result_q;
    out_flags_d = out_flags_q;
    case (state_q)
      ALU16_ST_IDLE: begin
        if (start) begin
          // Operands and F are latched so the ALU sees stable values while
          // stalled and later input changes cannot leak into the result.
          op_d    = op;
          opa_d   = opa;
          opb_d   = opb;
          flags_d = in_flags;
          state_d = ALU16_ST_LO;
`ifdef ALU16_FAST_INCDEC_EN
          if (op == ALU16_INC || op == ALU16_DEC) begin
            result_d    = (op == ALU16_INC) ? (opa + 16'd1) : (opa - 16'd1);
            out_flags_d = in_flags;
            state_d     = ALU16_ST_DONE;
          end
`endif
        end
      end
      ALU16_ST_LO: begin
        if (alu_gnt) begin
          res_lo_d = alu_result;
          carry_d  = alu_out_flags.c;
          h_lo_d   = alu_out_flags.h;
          state_d  = ALU16_ST_HI;
        end
      end
      ALU16_ST_HI: begin
        if (alu_gnt) begin
          result_d    = {alu_result, res_lo_q};
          out_flags_d = alu16_merge_flags(op_q, flags_q, h_lo_q, carry_q,
                                          alu_out_flags.h, alu_out_flags.c);
          state_d     = ALU16_ST_DONE;
        end
      end
      default: state_d = ALU16_ST_IDLE;
    endcase
  end

  // Outputs and ALU operand selection
  always_comb begin
    busy         = (state_q != ALU16_ST_IDLE);
    done         = (state_q == ALU16_ST_DONE);
    alu_req      = 1'b0;
    alu_op       = ALU_NOP;
    alu_op1      = '0;
    alu_op2      = '0;
    alu_in_flags = '0;
    case (state_q)
      ALU16_ST_LO: begin
        alu_req = 1'b1;
        alu_op  = (op_q == ALU16_DEC) ? ALU_SUB : ALU_ADD;
        alu_op1 = opa_q[7:0];
        alu_op2 = (op_q == ALU16_ADD_HL || op_q == ALU16_ADD_SP) ? opb_q[7:0] : 8'h01;
      end
      ALU16_ST_HI: begin
        alu_req = 1'b1;
        alu_op  = (op_q == ALU16_DEC) ? ALU_SBC : ALU_ADC;
        alu_op1 = opa_q[15:8];
        case (op_q)
          ALU16_ADD_HL: alu_op2 = opb_q[15:8];
          ALU16_ADD_SP: alu_op2 = {8{opb_q[7]}};  // sign-extend e8
          default:      alu_op2 = 8'h00;
        endcase
        alu_in_flags.c = carry_q;
      end
      default: ;
    endcase
  end

  assign result    = result_q;
  assign out_flags = out_flags_q;

endmodule

// File: tb/tb_alu16_seq.sv
module tb_alu16_seq;
  import sm83_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  alu16_op_t   op = ALU16_ADD_HL;
  logic [15:0] opa = '0;
  logic [15:0] opb = '0;
  flags_t      in_flags = '0;
  logic        busy, done;
  logic [15:0] result;
  flags_t      out_flags;
  logic        alu_req;
  logic        alu_gnt = 1'b1;
  alu_op_t     alu_op;
  data_t       alu_op1, alu_op2;
  flags_t      alu_in_flags;
  data_t       alu_result;
  flags_t      alu_out_flags;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int req_cnt = 0;

  alu16_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .in_flags(in_flags), .busy(busy), .done(done), .result(result),
    .out_flags(out_flags), .alu_req(alu_req), .alu_gnt(alu_gnt),
    .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_in_flags(alu_in_flags), .alu_result(alu_result),
    .alu_out_flags(alu_out_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done)    done_cnt <= done_cnt + 1;
    if (alu_req) req_cnt  <= req_cnt + 1;
  end

  // SM83 8-bit ALU reference: H is the bit-3 carry/borrow, C the bit-7 one.
  always_comb begin
    logic [8:0] s;
    logic [4:0] hs;
    logic       ci;
    s  = '0;
    hs = '0;
    ci = alu_in_flags.c;
    alu_out_flags = '0;
    case (alu_op)
      ALU_ADD: begin s = {1'b0, alu_op1} + {1'b0, alu_op2};
                     hs = {1'b0, alu_op1[3:0]} + {1'b0, alu_op2[3:0]}; end
      ALU_ADC: begin s = {1'b0, alu_op1} + {1'b0, alu_op2} + {8'd0, ci};
                     hs = {1'b0, alu_op1[3:0]} + {1'b0, alu_op2[3:0]} + {4'd0, ci}; end
      ALU_SUB: begin s = {1'b0, alu_op1} - {1'b0, alu_op2};
                     hs = {1'b0, alu_op1[3:0]} - {1'b0, alu_op2[3:0]};
                     alu_out_flags.n = 1'b1; end
      ALU_SBC: begin s = {1'b0, alu_op1} - {1'b0, alu_op2} - {8'd0, ci};
                     hs = {1'b0, alu_op1[3:0]} - {1'b0, alu_op2[3:0]} - {4'd0, ci};
                     alu_out_flags.n = 1'b1; end
      default: ;
    endcase
    alu_result      = s[7:0];
    alu_out_flags.z = (s[7:0] == 8'h00) && (alu_op != ALU_NOP);
    alu_out_flags.h = hs[4];
    alu_out_flags.c = s[8];
  end

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Launch one op, optionally stall the LO pass for `stall` cycles, then
  // check latency, result and flags against hand-computed values.
  task automatic run_op(string tag, alu16_op_t o, logic [15:0] a, logic [15:0] b,
                        flags_t f, int stall, logic [15:0] exp_r, flags_t exp_f,
                        int exp_lat);
    int n;
    int lat;
    bit got;
    alu_op_t exp_lo_op;
    data_t   exp_lo_b;
    exp_lo_op = (o == ALU16_DEC) ? ALU_SUB : ALU_ADD;
    exp_lo_b  = (o == ALU16_ADD_HL || o == ALU16_ADD_SP) ? b[7:0] : 8'h01;
    @(negedge clk);
    op = o; opa = a; opb = b; in_flags = f; start = 1'b1;
    alu_gnt = (stall == 0);
    @(posedge clk);
    n = cyc;
    #1 start = 1'b0;
    in_flags = ~f;  // must be ignored after launch
    got = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30 && !got; k++) begin
      @(negedge clk);
      if (k <= stall) begin
        chk({tag, "_stall_req"}, 32'(alu_req), 32'd1);
        chk({tag, "_stall_op"},  32'(alu_op), 32'(exp_lo_op));
        chk({tag, "_stall_op1"}, 32'(alu_op1), 32'(a[7:0]));
        chk({tag, "_stall_op2"}, 32'(alu_op2), 32'(exp_lo_b));
      end else if (k == stall + 1) begin
        alu_gnt = 1'b1;
      end
      if (done) begin
        got = 1'b1;
        lat = cyc - n;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, 32'(result), 32'(exp_r));
    chk({tag, "_flags"}, 32'(out_flags), 32'(exp_f));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_held"}, 32'(result), 32'(exp_r));
  endtask

  initial begin
    int d0, r0, exp_lat_incdec, exp_req_incdec;
`ifdef ALU16_FAST_INCDEC_EN
    exp_lat_incdec = 1;
    exp_req_incdec = 0;
`else
    exp_lat_incdec = 3;
    exp_req_incdec = 2;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'(out_flags), 32'd0);
    chk("rst_req", 32'(alu_req), 32'd0);
    chk("rst_op", 32'(alu_op), 32'(ALU_NOP));
    chk("rst_op1", 32'(alu_op1), 32'd0);
    chk("rst_op2", 32'(alu_op2), 32'd0);
    chk("rst_inf", 32'(alu_in_flags), 32'd0);
    rst = 1'b0;

    // flags literal order: {z,n,h,c}
    run_op("addhl_h11", ALU16_ADD_HL, 16'h0FFF, 16'h0001, 4'b1000, 0, 16'h1000, 4'b1010, 3);
    run_op("addhl_wrap", ALU16_ADD_HL, 16'hFFFF, 16'h0001, 4'b0000, 0, 16'h0000, 4'b0011, 3);
    run_op("addsp_neg", ALU16_ADD_SP, 16'h0005, 16'h00FE, 4'b1100, 0, 16'h0003, 4'b0011, 3);
    run_op("addsp_zero", ALU16_ADD_SP, 16'hFFF8, 16'h0008, 4'b0000, 0, 16'h0000, 4'b0011, 3);
    run_op("addsp_m1", ALU16_ADD_SP, 16'h1000, 16'h00FF, 4'b0000, 0, 16'h0FFF, 4'b0000, 3);
    r0 = req_cnt;
    run_op("dec_wrap", ALU16_DEC, 16'h0000, 16'h5555, 4'b1111, 0, 16'hFFFF, 4'b1111, exp_lat_incdec);
    chk("dec_req_cycles", 32'(req_cnt - r0), 32'(exp_req_incdec));
    run_op("inc_wrap", ALU16_INC, 16'hFFFF, 16'h0000, 4'b0100, 0, 16'h0000, 4'b0100, exp_lat_incdec);
    run_op("addhl_stall", ALU16_ADD_HL, 16'h1234, 16'h0F0F, 4'b0000, 4, 16'h2143, 4'b0010, 7);

    // Reset while the high-byte pass is on the ALU
    d0 = done_cnt;
    @(negedge clk);
    op = ALU16_ADD_HL; opa = 16'h0FFF; opb = 16'h0001; in_flags = 4'b1000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_in_hi", 32'(alu_op), 32'(ALU_ADC));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_op", 32'(alu_op), 32'(ALU_NOP));
    chk("rstmid_result", 32'(result), 32'd0);
    chk("rstmid_flags", 32'(out_flags), 32'd0);
    repeat (4) @(negedge clk);
    chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);

    // start held high while busy must not relaunch or change operands
    d0 = done_cnt;
    @(negedge clk);
    op = ALU16_ADD_HL; opa = 16'h00FF; opb = 16'h0001; in_flags = 4'b0000; start = 1'b1;
    @(posedge clk);
    #1 opa = 16'h1111; opb = 16'h2222;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8 && !done; k++) @(negedge clk);
    chk("busy_start_result", 32'(result), 32'h0100);
    chk("busy_start_flags", 32'(out_flags), 32'(4'b0000));
    repeat (5) @(negedge clk);
    chk("busy_start_one_done", 32'(done_cnt - d0), 32'd1);
    chk("busy_start_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
